// File: rtl/uart_rx_if.sv
// Consumer-side handshake of the UART receiver: received byte, valid/ren
// acknowledge and the one-cycle error pulses.
interface uart_rx_if;
  logic [7:0] dout;
  logic       valid;
  logic       ren;
  logic       frame_err;
  logic       overrun;

  modport master (output dout, valid, frame_err, overrun, input ren);
  modport slave  (input dout, valid, frame_err, overrun, output ren);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop line synchroniser, mid-bit sampling, byte
// hand-off on valid/ren with framing-error and overrun pulses.
module uart_rx #(
  parameter int CLKS_PER_BIT = 1085,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      rx_in,
  uart_rx_if.master rx_bus
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;
  logic             sync_q, rx_s_q;

  // NOTE: every register updates with <= so all flops see pre-edge values,
  // independent of statement order. Synchroniser resets to idle-high so a
  // released reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q      <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      dout_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync_q      <= rx_in;
      rx_s_q      <= sync_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      dout_q      <= dout_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  // NOTE: every next-state signal gets a default before the case, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    dout_d      = dout_q;
    valid_d     = valid_q && !rx_bus.ren;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (rx_s_q) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            bit_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_s_q) begin
            // A read in the completion cycle frees the slot, so it is not an overrun.
            dout_d    = shift_q;
            valid_d   = 1'b1;
            overrun_d = valid_q && !rx_bus.ren;
            state_d   = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_HIGH: begin
        if (rx_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rx_bus.dout      = dout_q;
  assign rx_bus.valid     = valid_q;
  assign rx_bus.frame_err = frame_err_q;
  assign rx_bus.overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: table of single frames plus hand-written
// sequences for glitch, back-to-back, overrun, mid-frame reset and default rate.
module tb_uart_rx;
  localparam int CPB      = 16;
  localparam int CPB_DEF  = 1085;
  // Stop-sample edge after the line falls: 2 sync flops + 1 detect edge + half bit + 9 bits.
  localparam int LAT      = 3 + CPB / 2 + 9 * CPB;
  localparam int LAT_SPEC = CPB / 2 + 9 * CPB + 2;
  localparam int LAT_DEF  = CPB_DEF / 2 + 9 * CPB_DEF + 2;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic rx   = 1'b1;
  logic rx_d = 1'b1;
  always #4 clk = ~clk;

  uart_rx_if bus ();
  uart_rx_if bus_d ();

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (.clk(clk), .rst(rst), .rx_in(rx), .rx_bus(bus));
  uart_rx dut_def (.clk(clk), .rst(rst), .rx_in(rx_d), .rx_bus(bus_d));

  typedef struct {
    logic [7:0] data;
    int         stop_low;
    logic [7:0] exp_dout;
    logic       exp_valid;
    int         exp_ferr;
  } vec_t;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] rise_q[$];
  logic valid_prev = 1'b0;
  logic def_prev   = 1'b0;
  int   last_rise  = 0;
  int   def_rise   = 0;
  int   last_fall  = 0;
  int   valid_falls = 0;
  int   ferr_cnt   = 0;
  int   ovr_cnt    = 0;
  bit   auto_ren   = 1'b0;
  bit   manual_ren = 1'b0;
  bit   arm_ren    = 1'b0;
  int   ren_at     = 0;
  int   r0, f0, o0, vf0;

  // Observation and ren generation happen on the falling edge, away from the DUT edge.
  always @(negedge clk) begin
    if (bus.valid && !valid_prev) begin
      rise_q.push_back(bus.dout);
      last_rise = cyc;
    end
    if (!bus.valid && valid_prev) valid_falls++;
    if (bus.frame_err) ferr_cnt++;
    if (bus.overrun) ovr_cnt++;
    valid_prev = bus.valid;
    bus.ren = auto_ren ? bus.valid : (manual_ren || (cyc == ren_at - 1));
    if (bus_d.valid && !def_prev) def_rise = cyc;
    def_prev = bus_d.valid;
  end

  initial begin
    #480000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    tests++;
    if (act < lo || act > hi) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic set_line(input bit on_def, input logic v);
    if (on_def) rx_d = v;
    else        rx   = v;
  endtask

  // Called just after a falling edge; leaves the line idle for one bit at the end.
  task automatic send_frame(input logic [7:0] data, input int stop_low, input bit on_def);
    int cpb;
    cpb = on_def ? CPB_DEF : CPB;
    set_line(on_def, 1'b0);
    last_fall = cyc;
    if (arm_ren) ren_at = cyc + LAT;
    repeat (cpb) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      set_line(on_def, data[i]);
      repeat (cpb) @(negedge clk);
    end
    if (stop_low > 0) begin
      set_line(on_def, 1'b0);
      repeat (stop_low * cpb) @(negedge clk);
    end
    set_line(on_def, 1'b1);
    repeat (cpb) @(negedge clk);
    #1;
  endtask

  // One-cycle ren pulse; returns one cycle after the edge that sampled it.
  task automatic read_byte();
    manual_ren = 1'b1;
    @(negedge clk);
    #1 manual_ren = 1'b0;
    settle();
  endtask

  initial begin
    vec_t vecs[5];
    vecs[0] = '{8'hA5, 0, 8'hA5, 1'b1, 0};
    vecs[1] = '{8'h81, 3, 8'hA5, 1'b0, 1};
    vecs[2] = '{8'h42, 0, 8'h42, 1'b1, 0};
    vecs[3] = '{8'h01, 0, 8'h01, 1'b1, 0};
    vecs[4] = '{8'h80, 0, 8'h80, 1'b1, 0};
    bus_d.ren = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("reset dout", bus.dout, 8'h00);
    check("reset valid", bus.valid, 1'b0);
    check("reset frame_err", bus.frame_err, 1'b0);
    check("reset overrun", bus.overrun, 1'b0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    #1;

    // Single frames from the table
    for (int i = 0; i < 5; i++) begin
      r0 = rise_q.size();
      f0 = ferr_cnt;
      send_frame(vecs[i].data, vecs[i].stop_low, 1'b0);
      repeat (CPB) @(negedge clk);
      #1;
      check($sformatf("vec%0d dout", i), bus.dout, vecs[i].exp_dout);
      check($sformatf("vec%0d valid", i), bus.valid, vecs[i].exp_valid);
      check($sformatf("vec%0d frame_err pulses", i), ferr_cnt - f0, vecs[i].exp_ferr);
      if (vecs[i].exp_valid) begin
        check_range($sformatf("vec%0d latency", i), last_rise - last_fall,
                    LAT_SPEC - 1, LAT_SPEC + 1);
        check($sformatf("vec%0d valid rises", i), rise_q.size() - r0, 1);
        read_byte();
        check($sformatf("vec%0d valid after ren", i), bus.valid, 1'b0);
      end else begin
        check($sformatf("vec%0d no valid rise", i), rise_q.size() - r0, 0);
      end
    end

    // ren while idle is ignored
    read_byte();
    check("idle ren valid", bus.valid, 1'b0);
    check("idle ren dout", bus.dout, 8'h80);

    // Start-bit glitch
    r0 = rise_q.size(); f0 = ferr_cnt; o0 = ovr_cnt;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    #1;
    check("glitch valid", bus.valid, 1'b0);
    check("glitch rises", rise_q.size() - r0, 0);
    check("glitch flags", (ferr_cnt - f0) + (ovr_cnt - o0), 0);
    send_frame(8'h3C, 0, 1'b0);
    settle();
    check("after glitch dout", bus.dout, 8'h3C);
    check("after glitch valid", bus.valid, 1'b1);
    read_byte();

    // Back-to-back frames with ren on each valid
    auto_ren = 1'b1;
    r0 = rise_q.size(); f0 = ferr_cnt; o0 = ovr_cnt;
    send_frame(8'h00, 0, 1'b0);
    send_frame(8'hFF, 0, 1'b0);
    send_frame(8'h5A, 0, 1'b0);
    repeat (CPB) @(negedge clk);
    #1;
    auto_ren = 1'b0;
    check("b2b rises", rise_q.size() - r0, 3);
    if (rise_q.size() - r0 == 3) begin
      check("b2b byte0", rise_q[r0], 8'h00);
      check("b2b byte1", rise_q[r0 + 1], 8'hFF);
      check("b2b byte2", rise_q[r0 + 2], 8'h5A);
    end
    check("b2b frame_err", ferr_cnt - f0, 0);
    check("b2b overrun", ovr_cnt - o0, 0);
    check("b2b valid", bus.valid, 1'b0);

    // Overrun without ren
    r0 = rise_q.size(); o0 = ovr_cnt;
    send_frame(8'h11, 0, 1'b0);
    send_frame(8'h22, 0, 1'b0);
    settle();
    check("overrun pulses", ovr_cnt - o0, 1);
    check("overrun dout", bus.dout, 8'h22);
    check("overrun valid", bus.valid, 1'b1);
    check("overrun rises", rise_q.size() - r0, 1);
    read_byte();

    // Read in the completion cycle: no overrun, valid never drops
    send_frame(8'h11, 0, 1'b0);
    settle();
    o0 = ovr_cnt; vf0 = valid_falls;
    arm_ren = 1'b1;
    send_frame(8'h22, 0, 1'b0);
    arm_ren = 1'b0;
    settle();
    check("ren-at-completion overrun", ovr_cnt - o0, 0);
    check("ren-at-completion dout", bus.dout, 8'h22);
    check("ren-at-completion valid", bus.valid, 1'b1);
    check("ren-at-completion valid falls", valid_falls - vf0, 0);
    read_byte();

    // Reset in the middle of a frame
    send_frame(8'h99, 0, 1'b0);
    settle();
    check("pre-reset dout", bus.dout, 8'h99);
    fork
      send_frame(8'hC3, 0, 1'b0);
      begin
        repeat (3 * CPB) @(negedge clk);
        rst = 1'b1;
        settle();
        check("midreset dout", bus.dout, 8'h00);
        check("midreset valid", bus.valid, 1'b0);
        check("midreset flags", {bus.frame_err, bus.overrun}, 2'b00);
        r0 = rise_q.size(); f0 = ferr_cnt; o0 = ovr_cnt;
      end
    join
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    #1;
    check("post-reset valid", bus.valid, 1'b0);
    check("post-reset rises", rise_q.size() - r0, 0);
    check("post-reset flags", (ferr_cnt - f0) + (ovr_cnt - o0), 0);
    send_frame(8'h7E, 0, 1'b0);
    settle();
    check("post-reset dout", bus.dout, 8'h7E);
    check("post-reset frame valid", bus.valid, 1'b1);
    read_byte();

    // Default bit rate
    send_frame(8'hA5, 0, 1'b1);
    repeat (100) @(negedge clk);
    #1;
    check("default dout", bus_d.dout, 8'hA5);
    check("default valid", bus_d.valid, 1'b1);
    check_range("default latency", def_rise - last_fall, LAT_DEF - 1, LAT_DEF + 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver, 115200 baud from the 125 MHz system clock; counterpart of the existing uart_tx.
- Synchronises the asynchronous serial line and detects the start bit.
- Samples each bit at its centre and presents the received byte to the consumer on a valid/ren handshake.
- Sits between the board RX pin and the RPN command parser; reports framing errors and overruns as one-cycle pulses.

Parameters:
- CLKS_PER_BIT, 1085: clk cycles per bit, (1 s / 115200) / 8 ns. Must be >= 8.
- HALF_BIT, CLKS_PER_BIT/2 (integer division, 542 at default): cycles from start-edge detection to the start-bit centre check.

Ports:
- clk  input  1  system clock, 125 MHz, all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- rx_in  input  1  asynchronous serial line, idle high.
- ren  input  1  consumer read enable; acknowledges dout when valid=1.
- dout  output  8  last correctly received byte, LSB = first data bit.
- valid  output  1  dout holds an unread byte.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: byte completed while previous byte still unread.

Behaviour:
- Reset: rst high at a clk edge forces state IDLE, counters=0, shift register=0, dout=8'h00, valid=0, frame_err=0, overrun=0. Both synchroniser flops are set to 1, so no false start after reset. Reset mid-frame abandons the frame and reports no error.
- Synchroniser: two flops on rx_in; all logic uses the second-stage output rx_s.
- Bit counter: 0..7. Cycle counter: wide enough for CLKS_PER_BIT-1.
- IDLE: rx_s==0 -> START with cycle counter=0.
- START: increment each cycle. At counter==HALF_BIT-1, re-sample rx_s:
  - rx_s==0: go to DATA, counter=0, bit counter=0.
  - rx_s==1: glitch; return to IDLE, no flags.
- DATA: at counter==CLKS_PER_BIT-1, shift rx_s in at the MSB and shift right, so the first bit ends at bit 0. Reset the counter and increment the bit counter. After the 8th sample go to STOP.
- STOP: at counter==CLKS_PER_BIT-1, sample rx_s.
  - rx_s==1: in the next cycle, dout<=shift register, valid<=1; go to IDLE.
  - rx_s==0: in the next cycle, frame_err pulses for 1 cycle. dout and valid are unchanged. Go to WAIT_HIGH.
- WAIT_HIGH: stay until rx_s==1, then go to IDLE. This covers break conditions and prevents a false restart.
- Latency: the stop sample occurs HALF_BIT + 9*CLKS_PER_BIT cycles after the IDLE->START transition. valid rises one cycle later.
- Handshake:
  - valid=1 and ren=1 at an edge: valid=0 next cycle.
  - ren while valid=0 is ignored.
  - dout is stable while valid=1, unless overwritten by an overrun.
- Overrun: byte completes while valid=1 and ren=0 in that cycle. The new byte overwrites dout, valid stays 1, overrun pulses for 1 cycle.
- Simultaneous completion and ren=1 with valid=1: the new byte is loaded, valid stays 1, no overrun.
- Receiving continues without gaps: IDLE is re-entered right after a good stop sample, so back-to-back frames are accepted.

Test Plan:
- Use CLKS_PER_BIT=16 for speed; rerun one case at the default.
- Single byte 8'hA5 sent at the exact bit period -> valid=1 with dout=8'hA5 at 8+144+2 cycles (±1) after the rx_in falling edge. Pulse ren -> valid=0 next cycle.
- Back-to-back frames 8'h00, 8'hFF, 8'h5A with ren asserted on each valid -> three valid assertions with the correct values, no frame_err, no overrun.
- 4-cycle low glitch on idle rx_in -> state returns to IDLE, valid stays 0, no flags. A following frame 8'h3C is received correctly.
- Frame 8'h81 with stop bit held low for 3 bit times -> frame_err pulses exactly once, valid stays 0. Receiver resumes after the line goes high and then receives 8'h42 correctly.
- Two frames 8'h11 then 8'h22 without ren -> overrun pulses once, dout=8'h22, valid=1. Repeat with ren asserted in the completion cycle -> no overrun.
- Assert rst mid-DATA of frame 8'hC3 -> all outputs are 0 next cycle. Release rst with the line idle -> no spurious valid. A following frame 8'h7E is received correctly.
